// File: rtl/waveword_encoder.sv
// waveword_encoder: turns ramp segments (start, end, sample count) into packed
// waveWords {start[31:22], step[21:8], samples[7:0]} for the DA wave-word
// controller. The per-sample step is |end-start|<<6 divided by the sample count
// with a 16-cycle restoring divider. After the last segment a terminator word
// (samples = 0) is issued so the controller can finish the wave.
//
// Build option: define WWENC_SLOPE_SAT_EN to clamp out-of-range steps to
// +/-8191 and flag them on slope_sat; otherwise the step wraps to 14 bits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a segment, seg_ready high
// S_DIV   | 16 restoring-division cycles, one quotient bit per cycle
// S_ISSUE | ww_req pulse for the segment word
// S_WAIT  | holding the segment word until ww_done
// S_TERM  | ww_req pulse for the terminator word
// S_TWAIT | holding the terminator word until ww_done
// S_DONE  | seq_done pulse

module waveword_encoder (
    input  logic        clk,
    input  logic        rstn,
    input  logic        seg_valid,
    output logic        seg_ready,
    input  logic [9:0]  seg_start,
    input  logic [9:0]  seg_end,
    input  logic [7:0]  seg_samples,
    input  logic        seg_last,
    output logic        ww_req,
    output logic [31:0] ww_word,
    input  logic        ww_done,
    output logic        busy,
    output logic        seq_done,
    output logic        slope_sat
);

    typedef enum logic [2:0] {
        S_IDLE, S_DIV, S_ISSUE, S_WAIT, S_TERM, S_TWAIT, S_DONE
    } state_t;

    state_t      state;
    logic [9:0]  start_q;
    logic [9:0]  end_q;
    logic [7:0]  samples_q;
    logic        last_q;
    logic        neg_q;
    logic [15:0] dvd_q;
    logic [7:0]  rem_q;
    logic [15:0] quo_q;
    logic [3:0]  cnt_q;

    logic [10:0] delta_in;
    logic [9:0]  mag_in;
    logic [8:0]  shifted;
    logic        ge;
    logic [7:0]  rem_sub;
    logic [7:0]  rem_next;
    logic [15:0] quo_next;
    logic [13:0] quo_neg;
    logic [13:0] step;
    logic        sat_bit;

    assign seg_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Magnitude of the incoming level change; sign is kept separately so the
    // divider only ever works on unsigned values.
    always_comb begin
        delta_in = {1'b0, seg_end} - {1'b0, seg_start};
        mag_in   = delta_in[10] ? (~delta_in[9:0] + 10'd1) : delta_in[9:0];
    end

    // One restoring-division step plus the final step formatting, which is
    // only consumed on the last DIV cycle.
    always_comb begin
        shifted  = {rem_q, dvd_q[15]};
        ge       = (shifted >= {1'b0, samples_q});
        rem_sub  = 8'(shifted - {1'b0, samples_q});
        rem_next = ge ? rem_sub : shifted[7:0];
        quo_next = {quo_q[14:0], ge};
        quo_neg  = ~quo_next[13:0] + 14'd1;
`ifdef WWENC_SLOPE_SAT_EN
        sat_bit  = |quo_next[15:13];
        if (sat_bit)
            step = neg_q ? 14'h2001 : 14'h1FFF;
        else
            step = neg_q ? quo_neg : quo_next[13:0];
`else
        sat_bit  = 1'b0;
        step     = neg_q ? quo_neg : quo_next[13:0];
`endif
    end

    // Sequencing FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            start_q   <= '0;
            end_q     <= '0;
            samples_q <= '0;
            last_q    <= 1'b0;
            neg_q     <= 1'b0;
            dvd_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            ww_req    <= 1'b0;
            ww_word   <= '0;
            seq_done  <= 1'b0;
            slope_sat <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (seg_valid) begin
                        start_q   <= seg_start;
                        end_q     <= seg_end;
                        samples_q <= seg_samples;
                        last_q    <= seg_last;
                        neg_q     <= delta_in[10];
                        dvd_q     <= {mag_in, 6'b0};
                        rem_q     <= '0;
                        quo_q     <= '0;
                        cnt_q     <= 4'd15;
                        slope_sat <= 1'b0;
                        if (seg_samples == 8'd0) begin
                            // An empty segment closes the sequence at its start level.
                            ww_word <= {seg_start, 22'd0};
                            ww_req  <= 1'b1;
                            state   <= S_TERM;
                        end else begin
                            state   <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    dvd_q <= {dvd_q[14:0], 1'b0};
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        ww_word   <= {start_q, step, samples_q};
                        slope_sat <= sat_bit;
                        ww_req    <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ww_req <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (ww_done) begin
                        slope_sat <= 1'b0;
                        if (last_q) begin
                            ww_word <= {end_q, 22'd0};
                            ww_req  <= 1'b1;
                            state   <= S_TERM;
                        end else begin
                            state   <= S_IDLE;
                        end
                    end
                end
                S_TERM: begin
                    ww_req <= 1'b0;
                    state  <= S_TWAIT;
                end
                S_TWAIT: begin
                    if (ww_done) begin
                        seq_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    seq_done <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
